spi_cmd_assembler: RTL
======================

SPI_CMD_ASSEMBLER -- requirements
Module: spi_cmd_assembler

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, giving the number of command FIFO entries; legal values are 2, 4 and 8.
REQ-002 Port clk, input, 1 bit: the single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port cs, input, 1 bit: high while the SPI chip select is inactive; a high level aborts any partial frame.
REQ-005 Port word_ready, input, 1 bit: single-cycle pulse from the SPI secondary; marks a new received byte.
REQ-006 Port data_word_received, input, 8 bits: the received byte, valid when word_ready is high.
REQ-007 Port data_word_to_send, output, 8 bits: the status byte the SPI secondary loads as its next transmitted byte.
REQ-008 Port cmd_valid, output, 1 bit: the FIFO head holds a command.
REQ-009 Port cmd_ready, input, 1 bit: the consumer accepts the head command.
REQ-010 Port cmd_opcode, output, 8 bits: opcode of the head command.
REQ-011 Port cmd_payload, output, 32 bits: payload of the head command.
REQ-012 Port err_count, output, 8 bits: checksum error counter.

Function
REQ-013 A frame SHALL be exactly 6 bytes in this order: opcode, payload bytes P0 to P3 (P0 least significant), then checksum.
REQ-014 The checksum SHALL be the XOR of the 5 bytes before it.
REQ-015 The framing FSM SHALL have three states:
- S_OPCODE: the byte on word_ready is latched as the opcode and the running XOR is seeded with it; the FSM goes to S_PAYLOAD with the byte index at 0.
- S_PAYLOAD: each byte is stored at payload[8*idx+7:8*idx] and XORed into the running value; after idx 3 the FSM goes to S_CHECK.
- S_CHECK: the checksum byte is evaluated and the FSM always returns to S_OPCODE.
REQ-016 In S_CHECK, on a checksum match with an opcode other than 0x00, the command SHALL be pushed into the FIFO if a slot is free.
REQ-017 If the FIFO is full at that push, the frame SHALL be dropped and sticky flag ovf set.
REQ-018 On a checksum match with opcode 0x00 (NOP), nothing SHALL be pushed, and flags ovf and cerr SHALL be cleared.
REQ-019 On a checksum mismatch, the frame SHALL be dropped, sticky flag cerr set, and err_count incremented (see REQ-031).
REQ-020 cs high SHALL force the FSM to S_OPCODE and clear the index and running XOR in the same cycle; the partial frame is discarded, with no flag change and no error count.
REQ-021 If cs and word_ready are high in the same cycle, cs SHALL win and the byte is ignored.
REQ-022 The FIFO SHALL be first-in first-out; a pop occurs on a cycle where cmd_valid and cmd_ready are both high.
REQ-023 cmd_valid, cmd_opcode and cmd_payload SHALL be registered.
- A push into an empty FIFO makes cmd_valid high on the next clock edge.
- cmd_opcode and cmd_payload SHALL hold stable while cmd_valid is high and cmd_ready is low.
REQ-024 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full; the occupancy is then unchanged and ovf is not set.
REQ-025 Pointer and occupancy arithmetic SHALL wrap modulo FIFO_DEPTH, with an extra occupancy bit to distinguish full from empty.
REQ-026 data_word_to_send SHALL be registered and updated every cycle to {ovf, cerr, fsm_busy, 1'b0, free_slots[3:0]}.
- fsm_busy is 1 when the state is not S_OPCODE.
- free_slots = FIFO_DEPTH minus occupancy, taken after any push or pop of the current cycle.

Reset
REQ-027 While reset is high, the FSM SHALL be S_OPCODE, index 0 and running XOR 0x00.
REQ-028 While reset is high, the FIFO SHALL be empty and cmd_valid 0.
REQ-029 While reset is high, cmd_opcode and cmd_payload SHALL be 0, ovf, cerr and err_count 0, and data_word_to_send {4'b0000, FIFO_DEPTH[3:0]}.
REQ-030 Reset asserted mid-frame or with the FIFO non-empty SHALL discard all frame and FIFO content immediately.

Configuration
REQ-031 Macro SPI_CMD_ERRCNT_EN controls the error counter.
- Defined: err_count is an 8-bit counter that saturates at 0xFF, increments once per checksum mismatch, and is cleared by a valid NOP frame.
- Undefined: no counter logic is built and err_count SHALL be constant 0x00; cerr behaves identically in both cases.

Verification
REQ-032 Send frame 11 01 02 03 04 15 with cmd_ready=0 -> cmd_valid=1 one cycle after the checksum byte, cmd_opcode=0x11, cmd_payload=0x04030201, free_slots=3.
REQ-033 Send the same frame with checksum 0x16 -> no push, cerr=1, err_count=0x01 (0x00 without macro); then frame 00 00 00 00 00 00 -> cerr=0, err_count=0x00.
REQ-034 Send 5 valid frames with FIFO_DEPTH=4 and cmd_ready=0 -> occupancy 4 and ovf=1; pop all -> the first 4 opcodes come out in order, then cmd_valid=0.
REQ-035 With the FIFO full and cmd_ready=1 held, deliver a 5th valid frame -> the push and pop are simultaneous, ovf stays 0 and occupancy stays 4.
REQ-036 Raise cs after opcode 0x22 and P0, then send full frame 33 00 00 00 00 33 -> exactly one command, opcode 0x33, with no flags set.
REQ-037 Assert reset after 3 bytes with 2 entries queued -> cmd_valid=0 and data_word_to_send=0x04 (FIFO_DEPTH=4); the next 6-byte frame is accepted normally.

Source files
------------

// File: rtl/spi_cmd_assembler.sv
// SPI command assembler: frames 6-byte SPI commands, verifies the XOR checksum and queues them.
// Optional macro SPI_CMD_ERRCNT_EN builds the saturating checksum-error counter behind err_count.
module spi_cmd_assembler #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        word_ready,
  input  logic [7:0]  data_word_received,
  output logic [7:0]  data_word_to_send,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_opcode,
  output logic [31:0] cmd_payload,
  output logic [7:0]  err_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_OPCODE, S_PAYLOAD, S_CHECK} state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  idx;
  logic [7:0]  xor_acc;
  logic [7:0]  opcode_r;
  logic [31:0] payload_r;

  logic        byte_in;
  logic        latch_opcode;
  logic        store_payload;
  logic        check;
  logic        match;
  logic        push_req;
  logic        nop;
  logic        bad;

  logic [7:0]       op_mem [FIFO_DEPTH];
  logic [31:0]      pl_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] free_slots;
  logic             full;
  logic             pop;
  logic             push;
  logic             ovf_set;
  logic             ovf;
  logic             cerr;
  logic             ovf_next;
  logic             cerr_next;

  assign byte_in = word_ready & ~cs;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_OPCODE;
    else       state <= state_next;
  end

  // FSM next-state logic; cs overrides any byte in the same cycle
  always_comb begin
    state_next = state;
    if (cs) begin
      state_next = S_OPCODE;
    end else if (word_ready) begin
      case (state)
        S_OPCODE:  state_next = S_PAYLOAD;
        S_PAYLOAD: if (idx == 2'd3) state_next = S_CHECK;
        S_CHECK:   state_next = S_OPCODE;
        default:   state_next = S_OPCODE;
      endcase
    end
  end

  // FSM outputs: per-byte datapath strobes
  always_comb begin
    latch_opcode  = 1'b0;
    store_payload = 1'b0;
    check         = 1'b0;
    if (byte_in) begin
      case (state)
        S_OPCODE:  latch_opcode  = 1'b1;
        S_PAYLOAD: store_payload = 1'b1;
        S_CHECK:   check         = 1'b1;
        default:   latch_opcode  = 1'b0;
      endcase
    end
  end

  assign match    = (xor_acc == data_word_received);
  assign push_req = check & match & (opcode_r != 8'h00);
  assign nop      = check & match & (opcode_r == 8'h00);
  assign bad      = check & ~match;

  // Frame datapath: opcode, payload bytes and running XOR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= 2'd0;
      xor_acc   <= 8'h00;
      opcode_r  <= 8'h00;
      payload_r <= 32'h0;
    end else if (cs) begin
      idx     <= 2'd0;
      xor_acc <= 8'h00;
    end else if (latch_opcode) begin
      opcode_r <= data_word_received;
      xor_acc  <= data_word_received;
      idx      <= 2'd0;
    end else if (store_payload) begin
      payload_r[{idx, 3'b000} +: 8] <= data_word_received;
      xor_acc <= xor_acc ^ data_word_received;
      idx     <= idx + 2'd1;
    end else if (check) begin
      xor_acc <= 8'h00;
    end
  end

  // FIFO control; a pop frees the slot a simultaneous push needs
  assign full       = (count == DEPTH_C);
  assign pop        = cmd_valid & cmd_ready;
  assign push       = push_req & (~full | pop);
  assign ovf_set    = push_req & full & ~pop;
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);
  assign free_slots = DEPTH_C - count_next;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  assign ovf_next  = nop ? 1'b0 : (ovf_set ? 1'b1 : ovf);
  assign cerr_next = nop ? 1'b0 : (bad ? 1'b1 : cerr);

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr] <= opcode_r;
      pl_mem[wr_ptr] <= payload_r;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      cerr   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count <= count_next;
      ovf   <= ovf_next;
      cerr  <= cerr_next;
    end
  end

  // Registered head of queue; a push into an empty (or emptying) FIFO bypasses storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      cmd_opcode  <= 8'h00;
      cmd_payload <= 32'h0;
    end else begin
      cmd_valid <= (count_next != '0);
      if (push && (count == '0 || (pop && count == CNT_W'(1)))) begin
        cmd_opcode  <= opcode_r;
        cmd_payload <= payload_r;
      end else if (pop && count > CNT_W'(1)) begin
        cmd_opcode  <= op_mem[rd_ptr_inc];
        cmd_payload <= pl_mem[rd_ptr_inc];
      end
    end
  end

  // Status byte reflects the state after this cycle's updates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_word_to_send <= {4'b0000, 4'(FIFO_DEPTH)};
    else       data_word_to_send <= {ovf_next, cerr_next, state_next != S_OPCODE,
                                     1'b0, 4'(free_slots)};
  end

`ifdef SPI_CMD_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      err_q <= 8'h00;
    else if (nop)                   err_q <= 8'h00;
    else if (bad && err_q != 8'hFF) err_q <= err_q + 8'h01;
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule
